qmult_seq: RTL and testbench

//  Sequential signed-magnitude fixed-point multiplier (Q fractional bits, N total, MSB = sign).

---
 rtl/qmult_seq.sv | 149 ++++++++++++++
 tb/tb_qmult_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/qmult_seq.sv
// Sequential signed-magnitude Q-format multiplier: shift-add, one magnitude bit per cycle,
// valid/ready on both sides, truncating Q-alignment with a sticky-per-result overflow flag.
module qmult_seq #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] c,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int M  = N - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [M-1:0]   mag_a_q, mag_a_d;
  logic [M-1:0]   mag_b_q, mag_b_d;
  logic           sgn_q, sgn_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   c_q, c_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic [AW-1:0]  addend_s;
  logic [N:0]     result_s;

  // Align the 2Q-fraction product back to Q fractions; {ovf, sign, magnitude}.
  // Sign is dropped when the truncated magnitude is zero so -0 never leaves the block.
  function automatic logic [N:0] format_product(input logic [AW-1:0] p, input logic s);
    logic [M-1:0] mag;
    logic         ov;
    mag = p[Q+M-1:Q];
    ov  = |p[AW-1:Q+M];
    return {ov, s & (|mag), mag};
  endfunction

  assign addend_s = {{M{1'b0}}, mag_a_q} << cnt_q;
  assign result_s = format_product(acc_q, sgn_q);

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    sgn_d       = sgn_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          mag_a_d = a[N-2:0];
          mag_b_d = b[N-2:0];
          sgn_d   = a[N-1] ^ b[N-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mag_b_q[cnt_q]) begin
          acc_d = acc_q + addend_s;
        end else begin
          acc_d = acc_q;
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        // First DONE cycle registers the formatted result; the handshake is
        // only honoured once out_valid is actually visible downstream.
        if (!out_valid_q) begin
          c_d         = result_s[N-1:0];
          ovf_d       = result_s[N];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      sgn_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      sgn_q       <= sgn_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_qmult_seq.sv
// Self-checking bench for qmult_seq (Q=16, N=32): directed vector table, backpressure and
// reset corner sequences, then random operands against an arithmetic reference model.
module tb_qmult_seq;

  localparam int Q = 16;
  localparam int N = 32;
  localparam int LATENCY = N;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a, b, c;
  logic         in_valid, in_ready, ovf, out_valid, out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  qmult_seq #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product of magnitudes, then Q alignment by division.
  function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint unsigned ma, mb, p, cm;
    logic            ov, s;
    ma = {33'd0, x[30:0]};
    mb = {33'd0, y[30:0]};
    p  = ma * mb;
    cm = (p / 64'd65536) % 64'd2147483648;
    ov = (p / 64'd65536) >= 64'd2147483648;
    s  = (x[31] ^ y[31]) && (cm != 64'd0);
    return {ov, s, cm[30:0]};
  endfunction

  task automatic set_vec(input int i, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vc, input logic vo, input string nm);
    vecs[i].a = va; vecs[i].b = vb; vecs[i].c = vc; vecs[i].ovf = vo; vecs[i].name = nm;
  endtask

  // One transaction: accept, measure latency, optionally stall (and poke in_valid), handshake.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input int hold,
                        input bit poke, output logic [31:0] rc, output logic rovf,
                        output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    rc = c; rovf = ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke) begin
        in_valid = (h % 2 == 0);
        a = 32'h1234_5678 + 32'(h);
      end
      @(posedge clk);
      #1 chk("stall_stable", {31'd0, out_valid, in_ready, ovf, c},
             {31'd0, 1'b1, 1'b0, rovf, rc});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("handshake", {62'd0, out_valid, in_ready}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rc, ra, rb;
    logic        rovf;
    logic [32:0] exp_r;
    int          lat;
    bit          seen;

    set_vec(0,  32'h0001_8000, 32'h8002_0000, 32'h8003_0000, 1'b0, "1.5x-2.0");
    set_vec(1,  32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0, "0.5x0.5");
    set_vec(2,  32'h8000_8000, 32'h8000_8000, 32'h0000_4000, 1'b0, "-0.5x-0.5");
    set_vec(3,  32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, "underflow");
    set_vec(4,  32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 1'b1, "ovf256");
    set_vec(5,  32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, "maxx1");
    set_vec(6,  32'h8000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, "negzero_a");
    set_vec(7,  32'h0003_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, "negzero_b");
    set_vec(8,  32'h80FF_0000, 32'h0081_0000, 32'h807F_0000, 1'b1, "ovf_wrap_neg");
    set_vec(9,  32'h8100_0000, 32'h0100_0000, 32'h0000_0000, 1'b1, "ovf_wrap_zero");
    set_vec(10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_0000, 1'b1, "maxxmax");

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_outputs", {30'd0, in_ready, out_valid, ovf, c}, {30'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, 1'b0, rc, rovf, lat);
      chk({vecs[i].name, "_c"}, {32'd0, rc}, {32'd0, vecs[i].c});
      chk({vecs[i].name, "_ovf"}, {63'd0, rovf}, {63'd0, vecs[i].ovf});
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(LATENCY));
    end

    // Backpressure: 20-cycle stall with in_valid pulses that must be ignored.
    run_op(32'h0001_8000, 32'h8002_0000, 20, 1'b1, rc, rovf, lat);
    chk("bp_c", {32'd0, rc}, 64'h8003_0000);
    run_op(32'h0000_8000, 32'h0000_8000, 0, 1'b0, rc, rovf, lat);
    chk("after_bp_c", {32'd0, rc}, 64'h0000_4000);

    // Reset during BUSY: outputs clear asynchronously, operation is discarded.
    @(negedge clk);
    a = 32'h0001_8000; b = 32'h8002_0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {30'd0, in_ready, out_valid, ovf, c}, {30'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    chk("no_stale_valid", {63'd0, seen}, 64'd0);
    run_op(32'h8002_0000, 32'h0000_4000, 0, 1'b0, rc, rovf, lat);
    chk("post_reset_c", {32'd0, rc}, 64'h8000_8000);
    chk("post_reset_lat", 64'(lat), 64'(LATENCY));

    // Random operands with mixed magnitude ranges and random stalls.
    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: begin ra[30:0] = ra[30:0] >> $urandom_range(8, 20); rb[30:0] = rb[30:0] >> $urandom_range(8, 20); end
        1: rb[30:0] = rb[30:0] >> $urandom_range(12, 24);
        2: ra[30:0] = ra[30:0] >> $urandom_range(0, 30);
        default: ;
      endcase
      exp_r = ref_mul(ra, rb);
      run_op(ra, rb, $urandom_range(0, 3), 1'b0, rc, rovf, lat);
      chk("rand_result", {31'd0, rovf, rc}, {31'd0, exp_r});
      if (t % 10 == 0) chk("rand_lat", 64'(lat), 64'(LATENCY));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
